// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, fetch entry
// layout and the ROM legality check.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // The 33-bit sum makes a PC that wraps past 2^32 fail the range test too.
  function automatic logic pc_legal(input logic [ADDR_W-1:0] pc,
                                    input logic [ADDR_W:0]   limit);
    return (pc[1:0] == 2'b00) && (({1'b0, pc} + 33'd4) <= limit);
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// Decode-side stream. Handshake: a beat transfers on a rising edge where
// out_valid && out_ready; out_valid never depends on out_ready.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_sequencer_fifo.sv
// Small synchronous FIFO of fetch entries. Flush beats push; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM,
// buffers {pc, instr} pairs for decode and handles redirects and bad PCs.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128,
  parameter int          DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_instr,
  fetch_sequencer_if.master        dec,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     fault,
  output logic [ADDR_W-1:0]        fault_pc,
  output fetch_state_t             state,
  output logic [$clog2(DEPTH):0]   level
);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic              push, pop, flush, full, empty;
  fetch_entry_t      head, din;

  assign pop       = !empty && dec.out_ready;
  assign din       = '{pc: pc_q, instr: imem_instr};
  assign imem_addr = pc_q;

  // Redirect wins over everything; a pop in the same cycle still counts as taken.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (pc_legal(redirect_pc, MEM_LIMIT)) begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end else begin
        state_d    = FAULT;
        fault_pc_d = redirect_pc;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (!pc_legal(pc_q, MEM_LIMIT)) begin
            state_d    = FAULT;
            fault_pc_d = pc_q;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        FAULT: ;
        default: state_d = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (level),
    .full  (full),
    .empty (empty)
  );

  assign dec.out_valid = !empty;
  assign dec.out_instr = empty ? '0 : head.instr;
  assign dec.out_pc    = empty ? '0 : head.pc;
  assign fault         = (state_q == FAULT);
  assign fault_pc      = fault_pc_q;
  assign state         = state_q;
endmodule
